// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and default width.
package alu_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        CORRECT,
        DONE
    } div_state_t;

endpackage

// File: rtl/nonrestoring_divider_add_sub_unit.sv
// Ripple-carry add/subtract; subtract inverts b and injects carry-in.
module add_sub_unit #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] out_sum
);

    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b ^ {N{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign out_sum[i] = a[i] ^ bx[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
module nonrestoring_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_sum;
    logic             as_sub;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // CORRECT adds M back to the unshifted A; STEP works on shifted {A,Q}
    assign as_a   = (state == CORRECT) ? a_q : {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign as_sub = (state == STEP) && !a_q[WIDTH];

    add_sub_unit #(
        .N(WIDTH + 1)
    ) u_add_sub (
        .a      (as_a),
        .b      (m_q),
        .sub    (as_sub),
        .out_sum(as_sum)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = (m_q == '0) ? DONE : STEP;
            STEP:    if (count == '0) state_nxt = CORRECT;
            CORRECT: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_q         <= '0;
            m_q         <= '0;
            q_q         <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_q         <= {1'b0, divisor};
                        q_q         <= dividend;
                        a_q         <= '0;
                        count       <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                    end
                end
                LOAD: begin
                    if (m_q == '0) begin
                        quotient    <= '1;
                        remainder   <= q_q;
                        div_by_zero <= 1'b1;
                    end
                end
                STEP: begin
                    a_q   <= as_sum;
                    q_q   <= {q_q[WIDTH-2:0], ~as_sum[WIDTH]};
                    count <= count - 1'b1;
                end
                CORRECT: begin
                    quotient <= q_q;
                    if (a_q[WIDTH]) begin
                        a_q       <= as_sum;
                        remainder <= as_sum[WIDTH-1:0];
                    end else begin
                        remainder <= a_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for the non-restoring divider.
module tb_nonrestoring_divider;

    logic       clk;
    logic       rst_b;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         due;
    } exp_t;

    exp_t qu[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    logic seen = 1'b0;
    logic [7:0] last_q;
    logic [7:0] last_r;

    nonrestoring_divider dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (done) begin
                exp_t e;
                chk("busy_done", busy, 1);
                chk("pulse", prev_done, 0);
                if (qu.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = qu.pop_front();
                    chk("quot", quotient, e.q);
                    chk("rem", remainder, e.r);
                    chk("dz", div_by_zero, e.dz);
                    chk("latency", cyc, e.due);
                end
                last_q = quotient;
                last_r = remainder;
                seen   = 1'b1;
            end else if (seen) begin
                chk("hold_q", quotient, last_q);
                chk("hold_r", remainder, last_r);
            end
        end
        prev_done = done;
    end

    task automatic start_op(input logic [7:0] dd, input logic [7:0] dv);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        while (busy && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_wait", busy, 0);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        if (dv == 0) begin
            e.q  = 8'hff;
            e.r  = dd;
            e.dz = 1'b1;
            e.due = cyc + 2;
        end else begin
            e.q  = dd / dv;
            e.r  = dd % dv;
            e.dz = 1'b0;
            e.due = cyc + 11;
        end
        qu.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (qu.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", qu.size(), 0);
    endtask

    initial begin
        rst_b    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        rst_b = 1'b1;

        start_op(100, 7);
        drain();
        start_op(5, 0);
        drain();
        start_op(9, 3);
        drain();
        start_op(255, 1);
        start_op(3, 200);
        start_op(255, 255);
        start_op(0, 9);
        drain();

        // second start during an operation must be ignored
        start_op(200, 13);
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 50;
        divisor  = 2;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (4) @(posedge clk);

        // asynchronous reset mid-operation
        start_op(250, 3);
        repeat (4) @(posedge clk);
        #1;
        seen  = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_dz", div_by_zero, 0);
        qu.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (15) @(posedge clk);
        start_op(250, 3);
        drain();

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] dd;
            logic [7:0] dv;
            dd = 8'($urandom);
            dv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            start_op(dd, dv);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
